// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
//
// Contents: FSM state encoding, payload width, stop-bit count, parity type codes.

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_W    = 8;
    localparam int   UART_STOP_BITS = 1;
    localparam logic PAR_EVEN       = 1'b0;
    localparam logic PAR_ODD        = 1'b1;

endpackage

// File: rtl/tx_parity_gen.sv
// rtl/tx_parity_gen.sv - combinational parity generator for the UART transmitter
//
// Ports:
//   data    in  DATA_W  payload byte
//   par_typ in  1       0 = even, 1 = odd
//   parity  out 1       parity bit that makes the frame even/odd

module tx_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par_typ,
    output logic              parity
);

    // Even parity is the plain XOR-reduce; odd parity inverts it.
    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, one stop bit
//
// Ports:
//   clk        in  1        UART clock (shared with the receive path)
//   rst        in  1        synchronous active-high reset
//   p_data     in  DATA_W   byte to send, sampled on accept
//   data_valid in  1        send request, accepted when busy is low
//   par_en     in  1        insert parity bit
//   par_typ    in  1        0 = even, 1 = odd parity
//   prescale   in  PRESC_W  clock cycles per bit, 0 behaves as 1
//   tx_out     out 1        serial line, idle high (registered)
//   busy       out 1        frame in flight (registered)

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W  = UART_DATA_W,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  p_data,
    input  logic               data_valid,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tx_out,
    output logic               busy
);

    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    uart_state_e        state_q, state_d;
    logic [PRESC_W-1:0] cyc_q, cyc_d;
    logic [PRESC_W-1:0] last_q, last_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               par_en_q, par_en_d;
    logic               parity_q, parity_d;
    logic               parity_in;
    logic               bit_end;
    logic               tx_d;
    logic               busy_d;

    tx_parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data    (p_data),
        .par_typ (par_typ),
        .parity  (parity_in)
    );

    // Every non-idle state lasts exactly last_q+1 cycles.
    assign bit_end = (cyc_q == last_q);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        last_d   = last_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_en_d = par_en_q;
        parity_d = parity_q;

        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d  = START;
                    bit_d    = '0;
                    shreg_d  = p_data;
                    par_en_d = par_en;
                    parity_d = parity_in;
                    // Store P-1 so the bit boundary is a plain compare; prescale 0 maps to P=1.
                    last_d   = (prescale == '0) ? '0 : prescale - PRESC_W'(1);
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE) begin
            cyc_d = '0;
        end else begin
            cyc_d = bit_end ? '0 : cyc_q + PRESC_W'(1);
        end
    end

    // Outputs are decoded from the next-state values and registered, so the
    // line changes on the same edge the FSM moves.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = 1'b0;
            DATA:    tx_d   = shreg_d[0];
            PARITY:  tx_d   = parity_d;
            STOP:    tx_d   = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            last_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            last_q   <= last_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            tx_out   <= tx_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx

module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd0;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_W  (8),
        .PRESC_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_p(input logic [5:0] pr);
        return (pr == 6'd0) ? 1 : int'(pr);
    endfunction

    function automatic int frame_cycles(input bit pe, input int p);
        return (pe ? 11 : 10) * p;
    endfunction

    // Expected line level t cycles after the accept edge (t=1 is the first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] d, input bit pe, input bit pt,
                                    input int p, input int t);
        int b;
        if (t < 1 || t > frame_cycles(pe, p)) return 1'b1;
        b = (t - 1) / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe) return (($countones(d) % 2) == 1) ^ pt;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input bit pe, input int p, input int t);
        return (t >= 1 && t <= frame_cycles(pe, p));
    endfunction

    task automatic start_frame(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] pr);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = pr;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b1;
        p_data     = 8'h00;
        step();
        step();
        rst        = 1'b0;
        data_valid = 1'b0;
        checks++;
        if (tx_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx tx_out=%b expected 1", tx_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy busy=%b expected 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({tx_out, busy} !== 2'b10) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d tx_out/busy=%b%b expected 10", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_basic_a5();
        int n;
        n = frame_cycles(0, 8);
        start_frame(8'hA5, 0, 0, 6'd8);
        for (int t = 1; t <= n + 1; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'hA5, 0, 0, 8, t), exp_busy(0, 8, t)}) begin
                errors++;
                $display("FAIL a5_frame t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'hA5, 0, 0, 8, t), exp_busy(0, 8, t));
            end
            step();
        end
    endtask

    task automatic test_parity();
        int n;
        logic want;
        n = frame_cycles(1, 16);
        for (int k = 0; k < 2; k++) begin
            want = (k == 0);
            start_frame(8'h07, 1, k[0], 6'd16);
            for (int t = 1; t <= n + 1; t++) begin
                checks++;
                if ({tx_out, busy} !== {exp_tx(8'h07, 1, k[0], 16, t), exp_busy(1, 16, t)}) begin
                    errors++;
                    $display("FAIL parity_frame typ=%0d t=%0d tx_out/busy=%b%b expected %b%b", k, t,
                             tx_out, busy, exp_tx(8'h07, 1, k[0], 16, t), exp_busy(1, 16, t));
                end
                if (t == 150) begin
                    checks++;
                    if (tx_out !== want) begin
                        errors++;
                        $display("FAIL parity_bit typ=%0d tx_out=%b expected %b", k, tx_out, want);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_presc_zero();
        start_frame(8'hFF, 0, 0, 6'd0);
        for (int t = 1; t <= 11; t++) begin
            checks++;
            if ({tx_out, busy} !== {(t != 1), (t <= 10)}) begin
                errors++;
                $display("FAIL presc0 t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         (t != 1), (t <= 10));
            end
            step();
        end
    endtask

    task automatic test_ignore_midframe();
        int n;
        n = frame_cycles(1, 4);
        start_frame(8'h3C, 1, 1, 6'd4);
        for (int t = 1; t <= n + 6; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'h3C, 1, 1, 4, t), exp_busy(1, 4, t)}) begin
                errors++;
                $display("FAIL ignore_frame t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'h3C, 1, 1, 4, t), exp_busy(1, 4, t));
            end
            if (t == 10) begin
                p_data     = 8'hC3;
                par_en     = 1'b0;
                prescale   = 6'd2;
                data_valid = 1'b1;
            end
            if (t == 11) data_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        n1 = frame_cycles(0, 3);
        n2 = frame_cycles(1, 2);
        p_data     = 8'h5A;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd3;
        data_valid = 1'b1;
        step();
        // Request stays high with new contents; it must only take effect after busy falls.
        p_data   = 8'h81;
        par_en   = 1'b1;
        par_typ  = 1'b1;
        prescale = 6'd2;
        for (int t = 1; t <= n1 + 1; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'h5A, 0, 0, 3, t), exp_busy(0, 3, t)}) begin
                errors++;
                $display("FAIL held_first t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'h5A, 0, 0, 3, t), exp_busy(0, 3, t));
            end
            step();
        end
        data_valid = 1'b0;
        for (int t = 1; t <= n2 + 1; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'h81, 1, 1, 2, t), exp_busy(1, 2, t)}) begin
                errors++;
                $display("FAIL held_second t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'h81, 1, 1, 2, t), exp_busy(1, 2, t));
            end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        start_frame(8'hD2, 0, 0, 6'd8);
        for (int t = 1; t <= 34; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'hD2, 0, 0, 8, t), exp_busy(0, 8, t)}) begin
                errors++;
                $display("FAIL rst_pre t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'hD2, 0, 0, 8, t), exp_busy(0, 8, t));
            end
            step();
        end
        // Inside data bit 3 (a 0 for 0xD2); a simultaneous request must be dropped.
        rst        = 1'b1;
        data_valid = 1'b1;
        p_data     = 8'hFF;
        step();
        rst        = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({tx_out, busy} !== 2'b10) begin
                errors++;
                $display("FAIL rst_idle cycle=%0d tx_out/busy=%b%b expected 10", i, tx_out, busy);
            end
            step();
        end
        n = frame_cycles(1, 5);
        start_frame(8'h4B, 1, 0, 6'd5);
        for (int t = 1; t <= n + 1; t++) begin
            checks++;
            if ({tx_out, busy} !== {exp_tx(8'h4B, 1, 0, 5, t), exp_busy(1, 5, t)}) begin
                errors++;
                $display("FAIL rst_after t=%0d tx_out/busy=%b%b expected %b%b", t, tx_out, busy,
                         exp_tx(8'h4B, 1, 0, 5, t), exp_busy(1, 5, t));
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [5:0] pr;
        bit         pe;
        bit         pt;
        int         p;
        int         n;
        for (int f = 0; f < 25; f++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            pr = 6'($urandom_range(0, 12));
            p  = eff_p(pr);
            n  = frame_cycles(pe, p);
            start_frame(d, pe, pt, pr);
            for (int t = 1; t <= n + 1; t++) begin
                checks++;
                if ({tx_out, busy} !== {exp_tx(d, pe, pt, p, t), exp_busy(pe, p, t)}) begin
                    errors++;
                    $display("FAIL random f=%0d d=%h pe=%0d pt=%0d p=%0d t=%0d tx_out/busy=%b%b expected %b%b",
                             f, d, pe, pt, p, t, tx_out, busy, exp_tx(d, pe, pt, p, t), exp_busy(pe, p, t));
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_parity();
        test_presc_zero();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
